// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dbi_pkg.sv
// Shared defaults and helpers for the receive-side bus-invert decoder.
package gf180mcu_fd_sc_mcu9t5v0__dbi_pkg;

    localparam int DBI_WIDTH = 8;
    localparam int DBI_CNT_W = 8;

    // Toggle count above which a transmitter is expected to invert the bus.
    function automatic int dbi_thresh(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dbi_popcnt.sv
// Parameterised combinational population count.
module gf180mcu_fd_sc_mcu9t5v0__dbi_popcnt #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CW-1:0]    o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_cnt = o_cnt + CW'(i_vec[i]);
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dbi_dec.sv
// Bus-invert decoder: re-inverts flagged words, checks the minimum-toggle rule,
// and presents the result through a single registered valid/ready stage.
module gf180mcu_fd_sc_mcu9t5v0__dbi_dec
    import gf180mcu_fd_sc_mcu9t5v0__dbi_pkg::*;
#(
    parameter int WIDTH = DBI_WIDTH,
    parameter int CNT_W = DBI_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    inout  wire              VDD,
    inout  wire              VSS,
    input  logic [WIDTH-1:0] D,
    input  logic             DBI,
    input  logic             VALID_I,
    output logic             READY_O,
    output logic [WIDTH-1:0] Q,
    output logic             VALID_O,
    input  logic             READY_I,
    output logic             ERR,
    output logic [CNT_W-1:0] ERRCNT
);

    localparam int            HW     = $clog2(WIDTH + 1);
    localparam logic [HW-1:0] THRESH = HW'(dbi_thresh(WIDTH));

    logic [WIDTH-1:0] r_pb;
    logic [WIDTH-1:0] w_x;
    logic [HW-1:0]    w_hd;
    logic             w_exp;
    logic             w_err;
    logic             w_accept;

    // Supply pins have no logic function; tie them off into a discarded net.
    wire w_unused_supply = VDD ^ VSS;

    assign READY_O  = !VALID_O || READY_I;
    assign w_accept = VALID_I && READY_O;
    assign w_x      = DBI ? ~D : D;

    gf180mcu_fd_sc_mcu9t5v0__dbi_popcnt #(
        .WIDTH (WIDTH),
        .CW    (HW)
    ) u_popcnt (
        .i_vec (w_x ^ r_pb),
        .o_cnt (w_hd)
    );

    // A tie is encoded without inversion.
    assign w_exp = (w_hd > THRESH);
    assign w_err = (DBI != w_exp);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q       <= '0;
            ERR     <= 1'b0;
            VALID_O <= 1'b0;
            ERRCNT  <= '0;
            r_pb    <= '0;
        end else if (w_accept) begin
            Q       <= w_x;
            ERR     <= w_err;
            VALID_O <= 1'b1;
            r_pb    <= D;
            if (w_err && (ERRCNT != '1)) begin
                ERRCNT <= ERRCNT + 1'b1;
            end
        end else if (VALID_O && READY_I) begin
            VALID_O <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dbi_dec.sv
// Self-checking bench for the bus-invert decoder (WIDTH=8, plus a CNT_W=2 copy).
module tb_gf180mcu_fd_sc_mcu9t5v0__dbi_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d   = '0;
    logic       dbi = 1'b0;
    logic       vi  = 1'b0;
    logic       ri  = 1'b1;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    logic       rdy_o, vo, err;
    logic [7:0] q, cnt;
    logic       rdy_o2, vo2, err2;
    logic [7:0] q2;
    logic [1:0] cnt2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__dbi_dec #(.WIDTH(8), .CNT_W(8)) dut (
        .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .D(d), .DBI(dbi),
        .VALID_I(vi), .READY_O(rdy_o), .Q(q), .VALID_O(vo), .READY_I(ri),
        .ERR(err), .ERRCNT(cnt)
    );

    gf180mcu_fd_sc_mcu9t5v0__dbi_dec #(.WIDTH(8), .CNT_W(2)) dut2 (
        .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .D(d), .DBI(dbi),
        .VALID_I(vi), .READY_O(rdy_o2), .Q(q2), .VALID_O(vo2), .READY_I(ri),
        .ERR(err2), .ERRCNT(cnt2)
    );

    typedef struct {
        logic [7:0] d;
        logic       dbi;
        logic [7:0] q;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vi  = 1'b0;
        #7;
        rst = 1'b0;
        tick();
    endtask

    // Reference model: decoder state expressed as a list of rules, not registers.
    logic       m_v;
    logic [7:0] m_q, m_pb, m_cnt;
    logic       m_err;
    int         m_cnt2;

    task automatic model_reset();
        m_v = 0; m_q = 0; m_pb = 0; m_cnt = 0; m_err = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge(input logic [7:0] dd, input logic db, input logic v, input logic r);
        logic [7:0] x;
        int         hd;
        logic       bad;
        if (v && (!m_v || r)) begin
            x   = db ? ~dd : dd;
            hd  = $countones(x ^ m_pb);
            bad = (db != (hd > 4));
            m_q = x; m_err = bad; m_v = 1; m_pb = dd;
            if (bad && m_cnt != 8'hFF) m_cnt = m_cnt + 1;
            if (bad && m_cnt2 < 3) m_cnt2++;
        end else if (m_v && r) begin
            m_v = 0;
        end
    endtask

    vec_t tbl[7];

    initial begin
        logic [7:0] prev_bus, word, sent;
        logic       inv;

        tbl[0] = '{8'h00, 1'b1, 8'hFF, 1'b0, 8'd0};
        tbl[1] = '{8'h0F, 1'b0, 8'h0F, 1'b0, 8'd0};  // tie: no invert
        tbl[2] = '{8'h00, 1'b1, 8'hFF, 1'b1, 8'd1};  // HD=4 but inverted
        tbl[3] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'd1};
        tbl[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1, 8'd2};  // HD=8 not inverted
        tbl[5] = '{8'hFF, 1'b1, 8'h00, 1'b0, 8'd2};
        tbl[6] = '{8'h01, 1'b0, 8'h01, 1'b1, 8'd3};  // HD=7 vs PB=FF

        #3;
        chk("rst_vo", vo, 0);
        chk("rst_q", q, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", cnt, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", rdy_o, 1);

        // Table stream at full rate
        ri = 1'b1;
        vi = 1'b1;
        for (int i = 0; i < 7; i++) begin
            d = tbl[i].d; dbi = tbl[i].dbi;
            tick();
            chk($sformatf("tbl%0d_vo", i), vo, 1);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
        end
        vi = 1'b0;
        tick();
        chk("drain_vo", vo, 0);

        // Backpressure: PB=01, A5 has HD=3 -> clean
        vi = 1'b1; d = 8'hA5; dbi = 1'b0;
        tick();
        chk("bp_q0", q, 8'hA5);
        chk("bp_err0", err, 0);
        ri = 1'b0; d = 8'h5A;
        #1;
        chk("bp_ready_drop", rdy_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp%0d_q", i), q, 8'hA5);
            chk($sformatf("bp%0d_vo", i), vo, 1);
            chk($sformatf("bp%0d_ready", i), rdy_o, 0);
        end
        ri = 1'b1;
        #1;
        chk("bp_release_ready", rdy_o, 1);
        tick();
        chk("bp_q1", q, 8'h5A);
        chk("bp_vo1", vo, 1);
        chk("bp_err1", err, 1);   // 5A vs PB=A5 toggles all 8 lines
        chk("bp_cnt1", cnt, 4);
        vi = 1'b0;
        tick();
        chk("bp_nodup", vo, 0);

        // Saturation: alternating uninverted FF/00 always toggles 8 lines
        do_reset();
        vi = 1'b1; dbi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
            chk($sformatf("sat%0d_cnt2", i), cnt2, (i < 3) ? i + 1 : 3);
            chk($sformatf("sat%0d_cnt8", i), cnt, i + 1);
            chk($sformatf("sat%0d_err", i), err2, 1);
        end

        // Async reset between edges
        do_reset();
        vi = 1'b1; dbi = 1'b0;
        d = 8'hFF; tick();
        d = 8'h00; tick();
        chk("ar_pre_cnt", cnt, 2);
        chk("ar_pre_vo", vo, 1);
        vi = 1'b0; ri = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_vo", vo, 0);
        chk("ar_cnt", cnt, 0);
        chk("ar_cnt2", cnt2, 0);
        #1;
        rst = 1'b0; ri = 1'b1;
        vi = 1'b1; d = 8'hF0; dbi = 1'b0;
        tick();
        chk("ar_post_q", q, 8'hF0);
        chk("ar_post_err", err, 0);

        // Transmitter-encoded stream at full rate; transmitter's last bus = F0
        prev_bus = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            word = 8'($urandom);
            inv  = ($countones(word ^ prev_bus) > 4);
            sent = inv ? ~word : word;
            prev_bus = sent;
            d = sent; dbi = inv;
            tick();
            chk($sformatf("tx%0d_q", i), q, word);
            chk($sformatf("tx%0d_err", i), err, 0);
            chk($sformatf("tx%0d_vo", i), vo, 1);
        end
        chk("tx_cnt", cnt, 0);

        // Random handshake and data against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            d   = 8'($urandom);
            dbi = 1'($urandom);
            vi  = ($urandom_range(0, 3) != 0);
            ri  = ($urandom_range(0, 3) != 0);
            #1;
            chk($sformatf("rnd%0d_ready", i), rdy_o, (!m_v || ri));
            model_edge(d, dbi, vi, ri);
            tick();
            chk($sformatf("rnd%0d_vo", i), vo, m_v);
            if (m_v) begin
                chk($sformatf("rnd%0d_q", i), q, m_q);
                chk($sformatf("rnd%0d_err", i), err, m_err);
            end
            chk($sformatf("rnd%0d_cnt", i), cnt, m_cnt);
            chk($sformatf("rnd%0d_cnt2", i), cnt2, m_cnt2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
